// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the game-state controller and the rest of the game logic.
// The master side drives the pixel/button inputs; the controller is the slave.
interface game_state_ctrl_if;
    logic       start;
    logic       bm_hb_on;
    logic       exp_on;
    logic       enemy_on;
    logic       pickup_on;
    logic [2:0] lives;
    logic [2:0] state;
    logic       freeze;
    logic       gameover;
    logic       bm_visible;
    logic [1:0] hit_src;
    logic       pickup_ack;

    modport master (
        output start, bm_hb_on, exp_on, enemy_on, pickup_on,
        input  lives, state, freeze, gameover, bm_visible, hit_src, pickup_ack
    );

    modport slave (
        input  start, bm_hb_on, exp_on, enemy_on, pickup_on,
        output lives, state, freeze, gameover, bm_visible, hit_src, pickup_ack
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Bomberman game-state FSM: lives, hit freeze, post-hit invulnerability with
// sprite blink, and extra-life pickups.
module game_state_ctrl #(
    parameter int START_LIVES = 5,
    parameter int MAX_LIVES   = 5,
    parameter int RESPAWN_MAX = 50000000,
    parameter int INVULN_MAX  = 150000000,
    parameter int BLINK_BIT   = 22
) (
    input  logic               clk,
    input  logic               reset,
    game_state_ctrl_if.slave   gs
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        HIT      = 3'd2,
        INVULN   = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [2:0]  START_L     = 3'((START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES);
    localparam logic [2:0]  MAX_L       = 3'(MAX_LIVES);
    localparam logic [27:0] RESPAWN_END = 28'(RESPAWN_MAX - 1);
    localparam logic [27:0] INVULN_END  = 28'(INVULN_MAX - 1);

    state_t      state_r;
    logic [27:0] timer;
    logic [2:0]  lives_r;
    logic [1:0]  hit_src_r;
    logic        start_q;
    logic        pick_q;
    logic        ack_r;

    logic start_rise;
    logic hit;
    logic pick;
    logic pick_rise;

    assign start_rise = gs.start & ~start_q;
    assign hit        = gs.bm_hb_on & (gs.exp_on | gs.enemy_on);
    assign pick       = gs.bm_hb_on & gs.pickup_on;
    // Pickups are consumed on the edge only, so standing on one never refills twice.
    assign pick_rise  = pick & ~pick_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of lives_r/timer, whatever the order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            timer     <= '0;
            lives_r   <= 3'd0;
            hit_src_r <= 2'b00;
            start_q   <= 1'b0;
            pick_q    <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            start_q <= gs.start;
            pick_q  <= pick;
            ack_r   <= 1'b0;

            case (state_r)
                IDLE, GAMEOVER: begin
                    if (start_rise) begin
                        state_r   <= PLAY;
                        lives_r   <= START_L;
                        hit_src_r <= 2'b00;
                        timer     <= '0;
                    end
                end

                PLAY: begin
                    if (hit) begin
                        hit_src_r <= gs.exp_on ? 2'b01 : 2'b10;
                        timer     <= '0;
                        if (lives_r <= 3'd1) begin
                            state_r <= GAMEOVER;
                            lives_r <= 3'd0;
                        end else begin
                            state_r <= HIT;
                            lives_r <= lives_r - 3'd1;
                        end
                    end else if (pick_rise) begin
                        ack_r <= 1'b1;
                        if (lives_r < MAX_L) lives_r <= lives_r + 3'd1;
                    end
                end

                HIT: begin
                    if (timer == RESPAWN_END) begin
                        state_r <= INVULN;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 28'd1;
                    end
                end

                INVULN: begin
                    // Hits are ignored here, so a pickup is never pre-empted.
                    if (pick_rise) begin
                        ack_r <= 1'b1;
                        if (lives_r < MAX_L) lives_r <= lives_r + 3'd1;
                    end
                    if (timer == INVULN_END) begin
                        state_r <= PLAY;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 28'd1;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    timer   <= '0;
                end
            endcase
        end
    end

    assign gs.state      = state_r;
    assign gs.lives      = lives_r;
    assign gs.hit_src    = hit_src_r;
    assign gs.pickup_ack = ack_r;
    assign gs.freeze     = (state_r == IDLE) || (state_r == HIT) || (state_r == GAMEOVER);
    assign gs.gameover   = (state_r == GAMEOVER);

    // NOTE: default assignment first keeps this decode free of inferred latches.
    always_comb begin
        gs.bm_visible = 1'b1;
        case (state_r)
            HIT, GAMEOVER: gs.bm_visible = 1'b0;
            INVULN:        gs.bm_visible = ~timer[BLINK_BIT];
            default:       gs.bm_visible = 1'b1;
        endcase
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter START_LIVES, default 5: lives loaded on each game start.
REQ-002 Parameter MAX_LIVES, default 5: saturation ceiling for lives; SHALL be in 1..7.
REQ-003 Parameter RESPAWN_MAX, default 50000000: length of the HIT freeze, in cycles.
REQ-004 Parameter INVULN_MAX, default 150000000: length of the post-hit invulnerability window, in cycles.
REQ-005 Parameter BLINK_BIT, default 22: timer bit that drives the blink during invulnerability.
REQ-006 clk  in  1  system clock; the only clock; all flops are rising-edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  start button, level; only its rising edge is used.
REQ-009 bm_hb_on  in  1  current pixel lies inside bomberman's hitbox.
REQ-010 exp_on  in  1  current pixel lies inside an explosion.
REQ-011 enemy_on  in  1  current pixel lies inside an enemy.
REQ-012 pickup_on  in  1  current pixel lies inside an extra-life pickup.
REQ-013 lives  out  3  current life count.
REQ-014 state  out  3  FSM state code: IDLE=0, PLAY=1, HIT=2, INVULN=3, GAMEOVER=4.
REQ-015 freeze  out  1  disables bomberman movement and bomb placement.
REQ-016 gameover  out  1  high when state is GAMEOVER.
REQ-017 bm_visible  out  1  bomberman sprite enable.
REQ-018 hit_src  out  2  cause of the last hit: 00 none, 01 explosion, 10 enemy.
REQ-019 pickup_ack  out  1  one-cycle pulse when a pickup is consumed.

Function
REQ-020 The block SHALL register start once (start_q); start_rise = start & ~start_q.
REQ-021 The block SHALL define hit = bm_hb_on & (exp_on | enemy_on) and pick = bm_hb_on & pickup_on, both sampled every cycle.
REQ-022 The block SHALL use one 28-bit timer that clears to 0 on every state change and increments by 1 in HIT and INVULN.
REQ-023 IDLE: freeze=1; on start_rise -> PLAY, lives <= START_LIVES, hit_src <= 00.
REQ-024 PLAY: on hit -> HIT, lives <= lives-1, hit_src <= 01 if exp_on else 10; explosion has priority when both are set.
REQ-025 PLAY: if the decremented lives value would be 0, the FSM SHALL go to GAMEOVER instead of HIT, in the same cycle.
REQ-026 HIT: freeze=1, hits and pickups ignored; when timer == RESPAWN_MAX-1 -> INVULN.
REQ-027 INVULN: freeze=0, hits ignored, pickups allowed; when timer == INVULN_MAX-1 -> PLAY.
REQ-028 Pickup in PLAY/INVULN: on pick with no hit accepted that cycle, lives <= min(lives+1, MAX_LIVES) and pickup_ack=1 for one cycle; ack also fires when lives is already at MAX_LIVES (pickup consumed, no increment).
REQ-029 A pickup SHALL be ignored in the same cycle a hit is accepted: no increment, no ack.
REQ-030 While pick stays high, pickup_ack SHALL fire only on pick's rising edge (pick_q register), never on consecutive cycles.
REQ-031 GAMEOVER: freeze=1, gameover=1, lives=0; on start_rise -> PLAY, lives <= START_LIVES, hit_src <= 00.
REQ-032 start_rise SHALL be ignored in PLAY, HIT and INVULN.
REQ-033 bm_visible SHALL equal ~timer[BLINK_BIT] in INVULN, 0 in HIT and GAMEOVER, and 1 in IDLE and PLAY.
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path except through state.
REQ-035 lives SHALL never underflow below 0 or exceed MAX_LIVES.

Reset
REQ-036 Reset SHALL force state=IDLE, lives=0, timer=0, hit_src=00, start_q=0, pick_q=0, pickup_ack=0, freeze=1, gameover=0, bm_visible=1.
REQ-037 Reset asserted mid-HIT or mid-INVULN SHALL abort immediately to IDLE, and a start_rise SHALL be required before play resumes.

Verification (bench params: START_LIVES=2, MAX_LIVES=3, RESPAWN_MAX=4, INVULN_MAX=8, BLINK_BIT=1)
REQ-038 Reset then start pulse -> state 0 -> 1 the cycle after start_rise, lives=2, freeze=0.
REQ-039 PLAY, bm_hb_on=exp_on=enemy_on=1 for one cycle -> lives=1, hit_src=01, state=HIT for 4 cycles, then INVULN for 8 cycles with bm_visible pattern 1,1,0,0,1,1,0,0, then PLAY.
REQ-040 Hit held high throughout HIT/INVULN -> no further decrement; re-hit on the first PLAY cycle -> lives 1 -> 0, state=GAMEOVER, gameover=1.
REQ-041 PLAY with lives=2, pick held 5 cycles -> single pickup_ack pulse, lives=3; second pick edge -> ack pulses, lives stays 3.
REQ-042 Hit and pick asserted in the same PLAY cycle -> lives decrements, no ack; reset asserted during INVULN -> IDLE, lives=0; start_rise in GAMEOVER -> PLAY, lives=2, hit_src=00.
